id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the two-slot VLIW core: R slot (ALU) and S slot (ALU/load/store).
- Latches decoded register specifiers, operand data and control from decode, and drives the EX stage and the forwarding unit.
- Contains load-use hazard detection. A load in EX whose destination feeds an instruction in ID causes a one-cycle bubble and stalls IF/ID.
- Supports an external hold and a branch flush.

Parameters:
- DATA_W, 16, operand/immediate width.
- REG_W, 3, register specifier width; register 0 is hard-zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID bundle valid.
- id_rm, id_rn, id_rd  in  REG_W each  R-slot sources/destination.
- id_sm, id_sn, id_sd  in  REG_W each  S-slot sources/destination (id_sd is store-data source when id_s_mw=1).
- id_r_rw, id_s_rw  in  1 each  slot register-write enables.
- id_s_mr, id_s_mw  in  1 each  S-slot memory read/write.
- id_r_a, id_r_b, id_s_a, id_s_b, id_imm  in  DATA_W each  register-file operands, immediate.
- hold_i  in  1  external freeze (e.g. memory busy).
- flush_i  in  1  branch-taken squash of ID contents.
- ex_valid  out  1  EX bundle valid.
- ex_rm, ex_rn, ex_rd, ex_sm, ex_sn, ex_sd  out  REG_W each  registered specifiers.
- ex_r_rw, ex_s_rw, ex_s_mr, ex_s_mw  out  1 each  registered controls.
- ex_r_a, ex_r_b, ex_s_a, ex_s_b, ex_imm  out  DATA_W each  registered data.
- stall_o  out  1  combinational; 1 = IF/ID must not advance.
- bubble_cnt  out  16  bubble counter (only with feature).

Behaviour:
- Reset: all ex_* outputs are 0, state is RUN, and stall_o is 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- hazard (combinational) = ex_valid & ex_s_mr & ex_sd!=0 & id_valid & (ex_sd matches any of id_rm, id_rn, id_sm, id_sn).
  - id_sd is excluded; store data is covered by load-store forwarding.
- Priority per edge: reset > flush_i > hold_i > hazard > normal load.
- flush_i=1:
  - ex_valid<=0; all controls and specifiers <=0.
  - State->RUN; stall_o=0 even if hazard or hold_i is active.
- hold_i=1 (no flush): all ex_* regs hold, stall_o=1, state unchanged.
- State RUN, hazard=1:
  - Insert a bubble: ex_valid<=0, all controls <=0, all specifiers <=0, data regs don't-care (hold).
  - stall_o=1 in that cycle; next state BUBBLE.
- State RUN, no hazard: load the ID bundle. When id_valid=0, controls load as 0.
- State BUBBLE: stall_o=0, load the ID bundle normally, next state RUN.
  - hazard is 0 here by construction, because ex_valid=0.
- The bubble forces specifiers to 0 so downstream forwarding comparisons never match.
- Back-to-back loads each get exactly one bubble. Two loads in the same bundle are impossible (only the S slot loads).

Optional Feature:
- Macro ID_EX_BUBBLE_STATS_EN.
- With it: bubble_cnt is a 16-bit counter.
  - Reset to 0.
  - +1 on each cycle a hazard bubble is inserted (not on flush or hold).
  - Saturates at 16'hFFFF.
- Without it: bubble_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset applied mid-BUBBLE -> next cycle all ex_* = 0, stall_o=0, state RUN.
- EX holds load (ex_s_mr=1, ex_sd=3); ID has id_rm=3 -> stall_o=1; next cycle ex_valid=0, ex_r_rw=0; following cycle ex_rm=3 latched with stall_o=0.
- Load ex_sd=0, id_rn=0 -> no stall. Load ex_sd=5, ID store with id_sd=5 only -> no stall.
- Hazard and flush_i=1 in the same cycle -> stall_o=0, ex_valid=0, state stays RUN.
- hold_i=1 for 3 cycles with ex_rd=2 -> ex_* unchanged and stall_o=1 throughout; resumes on the first cycle hold_i=0.
- With ID_EX_BUBBLE_STATS_EN: 4 load-use pairs -> bubble_cnt=4. Preload the count to 16'hFFFE, then 3 bubbles -> bubble_cnt=16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX bundle interface: decode-side bundle and controls in, EX-side
// registered bundle, stall and bubble statistics out.
// Handshake: id_valid qualifies the ID bundle on every clock edge; stall_o is
// the ready-inverse back to IF/ID (1 = ID must present the same bundle again).
// Optional feature macro ID_EX_BUBBLE_STATS_EN only affects bubble_cnt content.
interface id_ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    // Decode side
    logic              id_valid;
    logic [REG_W-1:0]  id_rm, id_rn, id_rd;
    logic [REG_W-1:0]  id_sm, id_sn, id_sd;
    logic              id_r_rw, id_s_rw, id_s_mr, id_s_mw;
    logic [DATA_W-1:0] id_r_a, id_r_b, id_s_a, id_s_b, id_imm;
    logic              hold_i;
    logic              flush_i;

    // Execute side
    logic              ex_valid;
    logic [REG_W-1:0]  ex_rm, ex_rn, ex_rd;
    logic [REG_W-1:0]  ex_sm, ex_sn, ex_sd;
    logic              ex_r_rw, ex_s_rw, ex_s_mr, ex_s_mw;
    logic [DATA_W-1:0] ex_r_a, ex_r_b, ex_s_a, ex_s_b, ex_imm;
    logic              stall_o;
    logic [15:0]       bubble_cnt;

    // Decode stage / stimulus side
    modport master (
        output id_valid, id_rm, id_rn, id_rd, id_sm, id_sn, id_sd,
               id_r_rw, id_s_rw, id_s_mr, id_s_mw,
               id_r_a, id_r_b, id_s_a, id_s_b, id_imm, hold_i, flush_i,
        input  ex_valid, ex_rm, ex_rn, ex_rd, ex_sm, ex_sn, ex_sd,
               ex_r_rw, ex_s_rw, ex_s_mr, ex_s_mw,
               ex_r_a, ex_r_b, ex_s_a, ex_s_b, ex_imm, stall_o, bubble_cnt
    );

    // Pipeline register side
    modport slave (
        input  id_valid, id_rm, id_rn, id_rd, id_sm, id_sn, id_sd,
               id_r_rw, id_s_rw, id_s_mr, id_s_mw,
               id_r_a, id_r_b, id_s_a, id_s_b, id_imm, hold_i, flush_i,
        output ex_valid, ex_rm, ex_rn, ex_rd, ex_sm, ex_sn, ex_sd,
               ex_r_rw, ex_s_rw, ex_s_mr, ex_s_mw,
               ex_r_a, ex_r_b, ex_s_a, ex_s_b, ex_imm, stall_o, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the two-slot (R/S) VLIW core with load-use
// hazard detection, external hold and branch flush.
// Optional macro ID_EX_BUBBLE_STATS_EN: saturating 16-bit count of hazard
// bubbles on bubble_cnt; without it bubble_cnt is tied to zero.
// state_dbg exposes the FSM state (0 = RUN, 1 = BUBBLE).
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_stage_if.slave bus,
    output logic        state_dbg
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rm, rn, rd, sm, sn, sd;
        logic              r_rw, s_rw, s_mr, s_mw;
        logic [DATA_W-1:0] r_a, r_b, s_a, s_b, imm;
    } ex_t;

    ex_t    ex_q, ex_d;
    ex_t    id_bundle;
    state_t state_q, state_d;
    logic   hazard;

    // Squashed slot: no valid, no side effects, specifiers zeroed so the
    // forwarding comparators never match; data keeps its old value.
    function automatic ex_t squash(input ex_t e);
        ex_t s;
        s       = e;
        s.valid = 1'b0;
        s.rm    = '0;
        s.rn    = '0;
        s.rd    = '0;
        s.sm    = '0;
        s.sn    = '0;
        s.sd    = '0;
        s.r_rw  = 1'b0;
        s.s_rw  = 1'b0;
        s.s_mr  = 1'b0;
        s.s_mw  = 1'b0;
        return s;
    endfunction

    // Gather the ID bundle; controls are gated so an invalid bundle has no effect.
    always_comb begin
        id_bundle       = '0;
        id_bundle.valid = bus.id_valid;
        id_bundle.rm    = bus.id_rm;
        id_bundle.rn    = bus.id_rn;
        id_bundle.rd    = bus.id_rd;
        id_bundle.sm    = bus.id_sm;
        id_bundle.sn    = bus.id_sn;
        id_bundle.sd    = bus.id_sd;
        id_bundle.r_rw  = bus.id_r_rw & bus.id_valid;
        id_bundle.s_rw  = bus.id_s_rw & bus.id_valid;
        id_bundle.s_mr  = bus.id_s_mr & bus.id_valid;
        id_bundle.s_mw  = bus.id_s_mw & bus.id_valid;
        id_bundle.r_a   = bus.id_r_a;
        id_bundle.r_b   = bus.id_r_b;
        id_bundle.s_a   = bus.id_s_a;
        id_bundle.s_b   = bus.id_s_b;
        id_bundle.imm   = bus.id_imm;
    end

    // Load-use hazard: a load in EX writing a source read by the ID bundle.
    // id_sd is not compared; store data is served by load-store forwarding.
    always_comb begin
        hazard = ex_q.valid && ex_q.s_mr && (ex_q.sd != '0) && bus.id_valid &&
                 ((ex_q.sd == bus.id_rm) || (ex_q.sd == bus.id_rn) ||
                  (ex_q.sd == bus.id_sm) || (ex_q.sd == bus.id_sn));
    end

    // Next-state / next-bundle selection: flush > hold > hazard > load.
    always_comb begin
        ex_d        = ex_q;
        state_d     = state_q;
        bus.stall_o = 1'b0;
        if (bus.flush_i) begin
            ex_d    = squash(ex_q);
            state_d = ST_RUN;
        end else if (bus.hold_i) begin
            bus.stall_o = 1'b1;
        end else if ((state_q == ST_RUN) && hazard) begin
            ex_d        = squash(ex_q);
            state_d     = ST_BUBBLE;
            bus.stall_o = 1'b1;
        end else begin
            ex_d    = id_bundle;
            state_d = ST_RUN;
        end
    end

    // Pipeline register and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            state_q <= ST_RUN;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
        end
    end

    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_rm    = ex_q.rm;
    assign bus.ex_rn    = ex_q.rn;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.ex_sm    = ex_q.sm;
    assign bus.ex_sn    = ex_q.sn;
    assign bus.ex_sd    = ex_q.sd;
    assign bus.ex_r_rw  = ex_q.r_rw;
    assign bus.ex_s_rw  = ex_q.s_rw;
    assign bus.ex_s_mr  = ex_q.s_mr;
    assign bus.ex_s_mw  = ex_q.s_mw;
    assign bus.ex_r_a   = ex_q.r_a;
    assign bus.ex_r_b   = ex_q.r_b;
    assign bus.ex_s_a   = ex_q.s_a;
    assign bus.ex_s_b   = ex_q.s_b;
    assign bus.ex_imm   = ex_q.imm;
    assign state_dbg    = state_q;

`ifdef ID_EX_BUBBLE_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble_ins;

    // A bubble is inserted only on the hazard branch of the priority chain.
    assign bubble_ins = !bus.flush_i && !bus.hold_i && (state_q == ST_RUN) && hazard;

    // Saturating bubble count.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_ins && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`else
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes the expected EX view
// and stall for each cycle; a negedge monitor pops and compares.
module tb_id_ex_stage;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rm, rn, rd, sm, sn, sd;
        logic              r_rw, s_rw, s_mr, s_mw;
        logic [DATA_W-1:0] r_a, r_b, s_a, s_b, imm;
    } bundle_t;

    typedef struct packed {
        logic        chk;
        logic        stall;
        logic        state;
        logic [15:0] cnt;
        bundle_t     ex;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic state_dbg;

    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: what EX should show, whether the last squash was a
    // load-use bubble, and the number of such bubbles.
    bundle_t     m_ex;
    logic        m_bubble = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_known = 1'b0;

    id_ex_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic v, input int rm, input int rn, input int rd,
                                   input int sm, input int sn, input int sd,
                                   input logic rrw, input logic srw, input logic smr, input logic smw);
        bundle_t b;
        b.valid = v;
        b.rm = REG_W'(rm); b.rn = REG_W'(rn); b.rd = REG_W'(rd);
        b.sm = REG_W'(sm); b.sn = REG_W'(sn); b.sd = REG_W'(sd);
        b.r_rw = rrw; b.s_rw = srw; b.s_mr = smr; b.s_mw = smw;
        b.r_a = DATA_W'($urandom); b.r_b = DATA_W'($urandom);
        b.s_a = DATA_W'($urandom); b.s_b = DATA_W'($urandom);
        b.imm = DATA_W'($urandom);
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        return mk($urandom_range(0, 9) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    endfunction

    // Driver: apply one cycle of inputs, record expectation, advance the model.
    task automatic step(input bundle_t b, input logic h, input logic f, input logic r,
                        output logic stall_exp);
        exp_t    e;
        logic    haz;
        bundle_t cleared;
        @(posedge clk);
        #1;
        reset       = r;
        bus.hold_i  = h;
        bus.flush_i = f;
        bus.id_valid = b.valid;
        bus.id_rm = b.rm; bus.id_rn = b.rn; bus.id_rd = b.rd;
        bus.id_sm = b.sm; bus.id_sn = b.sn; bus.id_sd = b.sd;
        bus.id_r_rw = b.r_rw; bus.id_s_rw = b.s_rw;
        bus.id_s_mr = b.s_mr; bus.id_s_mw = b.s_mw;
        bus.id_r_a = b.r_a; bus.id_r_b = b.r_b;
        bus.id_s_a = b.s_a; bus.id_s_b = b.s_b; bus.id_imm = b.imm;

        // A valid load in EX whose nonzero destination is an ID source operand.
        haz = m_ex.valid && m_ex.s_mr && (m_ex.sd != 0) && b.valid &&
              (m_ex.sd == b.rm || m_ex.sd == b.rn || m_ex.sd == b.sm || m_ex.sd == b.sn);

        stall_exp = f ? 1'b0 : (h ? 1'b1 : haz);
        e.chk   = m_known && !r;
        e.stall = stall_exp;
        e.state = m_bubble;
`ifdef ID_EX_BUBBLE_STATS_EN
        e.cnt   = m_cnt;
`else
        e.cnt   = 16'h0000;
`endif
        e.ex    = m_ex;
        exp_q.push_back(EXP_W'(e));

        cleared = '0;
        cleared.r_a = m_ex.r_a; cleared.r_b = m_ex.r_b;
        cleared.s_a = m_ex.s_a; cleared.s_b = m_ex.s_b; cleared.imm = m_ex.imm;
        if (r) begin
            m_ex = '0; m_bubble = 1'b0; m_cnt = '0; m_known = 1'b1;
        end else if (f) begin
            m_ex = cleared; m_bubble = 1'b0;
        end else if (h) begin
            // frozen
        end else if (haz) begin
            m_ex = cleared; m_bubble = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_ex = b;
            m_ex.r_rw = b.r_rw & b.valid; m_ex.s_rw = b.s_rw & b.valid;
            m_ex.s_mr = b.s_mr & b.valid; m_ex.s_mw = b.s_mw & b.valid;
            m_bubble = 1'b0;
        end
    endtask

    // Monitor / scoreboard: compare the DUT view against the oldest expectation.
    always @(negedge clk) begin
        exp_t    e;
        bundle_t act;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            if (e.chk) begin
                act.valid = bus.ex_valid;
                act.rm = bus.ex_rm; act.rn = bus.ex_rn; act.rd = bus.ex_rd;
                act.sm = bus.ex_sm; act.sn = bus.ex_sn; act.sd = bus.ex_sd;
                act.r_rw = bus.ex_r_rw; act.s_rw = bus.ex_s_rw;
                act.s_mr = bus.ex_s_mr; act.s_mw = bus.ex_s_mw;
                act.r_a = bus.ex_r_a; act.r_b = bus.ex_r_b;
                act.s_a = bus.ex_s_a; act.s_b = bus.ex_s_b; act.imm = bus.ex_imm;
                check("stall_o", 128'(bus.stall_o), 128'(e.stall));
                check("ex_bundle", 128'(act), 128'(e.ex));
                check("state", 128'(state_dbg), 128'(e.state));
                check("bubble_cnt", 128'(bus.bubble_cnt), 128'(e.cnt));
            end
        end
    end

    // Stimulus
    initial begin
        bundle_t nop, b, ld3, use3;
        logic    st;
        nop = '0;
        bus.hold_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset
        step(nop, 1'b0, 1'b0, 1'b1, st);
        step(nop, 1'b0, 1'b0, 1'b1, st);
        step(nop, 1'b0, 1'b0, 1'b0, st);

        // Load r3 then R-slot reads r3: one bubble, then the bundle lands.
        ld3  = mk(1, 0, 0, 0, 1, 2, 3, 0, 1, 1, 0);
        use3 = mk(1, 3, 4, 5, 0, 0, 0, 1, 0, 0, 0);
        step(ld3, 0, 0, 0, st);
        step(use3, 0, 0, 0, st);
        step(use3, 0, 0, 0, st);
        step(nop, 0, 0, 0, st);

        // Load to r0 with r0 sources: no stall.
        step(mk(1, 0, 0, 0, 1, 2, 0, 0, 1, 1, 0), 0, 0, 0, st);
        step(mk(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, st);
        // Load r5 then store whose data source is r5 only: no stall.
        step(mk(1, 0, 0, 0, 1, 2, 5, 0, 1, 1, 0), 0, 0, 0, st);
        step(mk(1, 1, 2, 3, 4, 6, 5, 1, 0, 0, 1), 0, 0, 0, st);
        step(nop, 0, 0, 0, st);

        // Hazard coinciding with flush: flush wins.
        step(ld3, 0, 0, 0, st);
        step(use3, 0, 1, 0, st);
        step(nop, 0, 0, 0, st);

        // Hold for three cycles with ex_rd=2, then resume.
        step(mk(1, 1, 1, 2, 1, 1, 4, 1, 1, 0, 0), 0, 0, 0, st);
        b = mk(1, 6, 7, 1, 6, 7, 1, 1, 1, 0, 0);
        repeat (3) step(b, 1, 0, 0, st);
        step(b, 0, 0, 0, st);
        step(nop, 0, 0, 0, st);

        // Reset while in BUBBLE.
        step(ld3, 0, 0, 0, st);
        step(use3, 0, 0, 0, st);
        step(use3, 0, 0, 1, st);
        step(nop, 0, 0, 0, st);

        // Back-to-back loads: each dependent bundle gets exactly one bubble.
        step(ld3, 0, 0, 0, st);
        b = mk(1, 0, 0, 0, 3, 0, 4, 0, 1, 1, 0);
        step(b, 0, 0, 0, st);
        step(b, 0, 0, 0, st);
        b = mk(1, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        step(b, 0, 0, 0, st);
        step(b, 0, 0, 0, st);
        step(nop, 0, 0, 0, st);

        // Four more load-use pairs (sources in S slot this time).
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 0, 0, 0, 0, 0, i + 1, 0, 1, 1, 0), 0, 0, 0, st);
            b = mk(1, 0, 0, 0, 0, i + 1, 0, 0, 1, 0, 0);
            step(b, 0, 0, 0, st);
            step(b, 0, 0, 0, st);
        end

        // Random traffic; a stalled bundle is re-presented like a real IF/ID.
        b = rand_bundle();
        for (int i = 0; i < 3000; i++) begin
            logic h, f, r;
            h = ($urandom_range(0, 99) < 8);
            f = ($urandom_range(0, 99) < 6);
            r = ($urandom_range(0, 199) == 0);
            step(b, h, f, r, st);
            if (!st || f || r) b = rand_bundle();
        end
        step(nop, 0, 0, 0, st);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("exp_q_drained", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
